// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: requester 1 has priority,
// and requester 0 is forced through after MAX_WAIT consecutive denied cycles.
module ram_arbiter #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 10,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req,
    input  logic          r0_write,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic          r1_req,
    input  logic          r1_write,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_write,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0] r_wait_cnt;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic          w_starve;
    logic          w_gnt0;
    logic          w_gnt1;

    // Grants are combinational and forced low while reset is held
    always_comb begin
        w_starve = r0_req && (r_wait_cnt == MAX_CNT);
        w_gnt0   = rst_n && r0_req && (!r1_req || w_starve);
        w_gnt1   = rst_n && r1_req && !w_gnt0;
    end

    // RAM port mux; idle cycles park on requester 0 with writes disabled
    always_comb begin
        ram_addr  = r0_addr;
        ram_wdata = r0_wdata;
        ram_write = 1'b0;
        if (w_gnt0) begin
            ram_write = r0_write;
        end else if (w_gnt1) begin
            ram_addr  = r1_addr;
            ram_wdata = r1_wdata;
            ram_write = r1_write;
        end
    end

    // Counts consecutive denied cycles of requester 0, saturating at MAX_WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!r0_req || w_gnt0) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt < MAX_CNT) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 && !r0_write;
            r_rvalid1 <= w_gnt1 && !r1_write;
        end
    end

    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;
    assign r0_rvalid = r_rvalid0;
    assign r1_rvalid = r_rvalid1;
    assign r0_rdata  = ram_rdata;
    assign r1_rdata  = ram_rdata;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DW, default 16, data width of the RAM and both requester ports.
REQ-002 Parameter AW, default 10, address width of the RAM and both requester ports.
REQ-003 Parameter MAX_WAIT, default 4, maximum consecutive cycles requester 0 is denied before it is forced to win; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 r0_req / r1_req  input  1 each  access request from requester 0 (CPU) / requester 1 (display).
REQ-007 r0_write / r1_write  input  1 each  1 = write, 0 = read; qualified by the matching req.
REQ-008 r0_addr / r1_addr  input  AW each  access address.
REQ-009 r0_wdata / r1_wdata  input  DW each  write data.
REQ-010 r0_gnt / r1_gnt  output  1 each  combinational grant; the access completes in the cycle gnt is high.
REQ-011 r0_rvalid / r1_rvalid  output  1 each  registered; read data valid for that requester.
REQ-012 r0_rdata / r1_rdata  output  DW each  both driven directly from ram_rdata.
REQ-013 ram_addr  output  AW; ram_write  output  1; ram_wdata  output  DW  drive the single-port RAM.
REQ-014 ram_rdata  input  DW  RAM read data, valid one cycle after the address is presented.

Function
REQ-015 At most one of r0_gnt and r1_gnt shall be high in any cycle; a gnt is high only when the matching req is high.
REQ-016 Default priority: requester 1 wins when both request, unless the starve condition (REQ-018) holds, in which case requester 0 wins.
REQ-017 wait_cnt (8 bits): +1 per cycle with r0_req=1 and r0_gnt=0, saturating at MAX_WAIT; cleared to 0 in any cycle with r0_gnt=1 or r0_req=0.
REQ-018 Starve condition: r0_req=1 and wait_cnt==MAX_WAIT.
REQ-019 A single requester shall be granted in the same cycle it requests, with zero arbitration latency.
REQ-020 ram_addr, ram_wdata and ram_write shall follow the granted requester's addr, wdata and write; ram_write = granted write.
REQ-021 No grant: ram_write=0, ram_addr=r0_addr, ram_wdata=r0_wdata.
REQ-022 A granted read sets that requester's rvalid high in exactly the next cycle, for one cycle; a granted write produces no rvalid.
REQ-023 Read latency from gnt cycle to rvalid: 1 cycle. Back-to-back reads shall give rvalid on consecutive cycles.
REQ-024 A requester holds req, write, addr and wdata stable until granted; the arbiter stores no request.
REQ-025 Read and write to the same address in consecutive cycles: the read returns the data the RAM returns, with no forwarding in the arbiter.
REQ-026 Throughput: one access per cycle in total, with no idle cycles inserted between grants.

Reset
REQ-027 While rst_n=0: wait_cnt=0, r0_rvalid=0, r1_rvalid=0, r0_gnt=0, r1_gnt=0 and ram_write=0, regardless of req inputs.
REQ-028 Reset asserted one cycle after a read grant clears the pending rvalid; the read is discarded and not replayed.
REQ-029 The first rising clk edge after rst_n deasserts shall arbitrate normally.

Verification
REQ-030 r0_req only: read addr 0x005 -> r0_gnt=1 same cycle, ram_addr=0x005, r0_rvalid=1 next cycle with r0_rdata equal to the RAM content.
REQ-031 r0_req and r1_req held high continuously with MAX_WAIT=4 -> r1 is granted 4 cycles, r0 in the 5th cycle, and the pattern repeats every 5 cycles.
REQ-032 r1 write 0xBEEF @0x010 granted, then r0 read @0x010 in the next cycle -> r0_rvalid next cycle with r0_rdata=0xBEEF.
REQ-033 r0_req drops after 2 denied cycles, then re-asserts together with r1_req -> wait_cnt restarts from 0 and r1 wins 4 more cycles.
REQ-034 rst_n low during a cycle with both reqs high -> no gnt, ram_write=0, no rvalid in the following cycle.
REQ-035 Random req/write/addr for 10k cycles against a reference model -> one-hot-or-zero grants, no starvation beyond MAX_WAIT, and RAM contents match.
